// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared memory-op encodings, state codes and byte-count helpers
// for the MEM stage and the load extender.
package mem_access_stage_pkg;

    localparam int MEM_BIT   = 4;
    localparam int STORE_BIT = 3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic RstEnable = 1'b0;
    localparam logic True      = 1'b1;
    localparam logic False     = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index of the final byte: 0 for byte, 1 for half, 3 for word.
    function automatic logic [1:0] last_byte(input logic [2:0] funct3);
        return funct3[1:0] == F3_SB[1:0] ? 2'd0 :
               funct3[1:0] == F3_SH[1:0] ? 2'd1 : 2'd3;
    endfunction

    // funct3[1:0]=11 has no width encoding, so it behaves as a non-memory op.
    function automatic logic is_mem(input logic [4:0] op);
        return op[MEM_BIT] && op[1:0] != 2'b11 && (op[1:0] != F3_SW[1:0] || True);
    endfunction

endpackage

// File: rtl/mem_access_stage_load_extender.sv
// load_extender: sign- or zero-extends an assembled little-endian load buffer
// according to the load funct3.
module load_extender
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] data,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    always_comb
        result = funct3 == F3_LB  ? {{24{data[7]}}, data[7:0]}   :
                 funct3 == F3_LH  ? {{16{data[15]}}, data[15:0]} :
                 funct3 == F3_LBU ? {24'd0, data[7:0]}           :
                 funct3 == F3_LHU ? {16'd0, data[15:0]}          :
                 funct3 == F3_LW  ? data                         : data;

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage that serialises loads/stores over an
// 8-bit memory port and stalls the pipeline until the transfer is complete.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int XLEN       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            wd_i,
    input  logic                  wreg_i,
    input  logic [XLEN-1:0]       wdata_i,
    input  logic [ADDR_WIDTH-1:0] memaddr_i,
    input  logic [4:0]            mem_op_i,
    input  logic [XLEN-1:0]       store_data_i,
    output logic [4:0]            wd_o,
    output logic                  wreg_o,
    output logic [XLEN-1:0]       wdata_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [7:0]            mem_wdata_o,
    input  logic [7:0]            mem_rdata_i,
    input  logic                  mem_ready_i
);

    state_t      state, nxt;
    logic [1:0]  cnt;
    logic [31:0] data_buf;
    logic [31:0] ext_data;
    logic [2:0]  f3_q;
    logic        store_q;

    load_extender u_ext (
        .data   (data_buf),
        .funct3 (f3_q),
        .result (ext_data)
    );

    // Opcode is latched at issue so a change on mem_op_i mid-transfer has no effect.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state       <= IDLE;
            cnt         <= '0;
            data_buf    <= '0;
            f3_q        <= '0;
            store_q     <= False;
            mem_req_o   <= False;
            mem_we_o    <= False;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: if (is_mem(mem_op_i)) begin
                    mem_req_o   <= True;
                    mem_we_o    <= mem_op_i[STORE_BIT];
                    mem_addr_o  <= memaddr_i;
                    mem_wdata_o <= store_data_i[7:0];
                    cnt         <= '0;
                    f3_q        <= mem_op_i[2:0];
                    store_q     <= mem_op_i[STORE_BIT];
                end
                XFER: if (mem_ready_i) begin
                    if (!store_q) data_buf[{cnt, 3'b000} +: 8] <= mem_rdata_i;
                    if (cnt == last_byte(f3_q)) begin
                        mem_req_o <= False;
                        mem_we_o  <= False;
                    end else begin
                        cnt         <= cnt + 2'd1;
                        mem_addr_o  <= mem_addr_o + ADDR_WIDTH'(1);
                        mem_wdata_o <= store_data_i[{cnt + 2'd1, 3'b000} +: 8];
                    end
                end
                DONE: begin
                    data_buf <= '0;
                    cnt      <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nxt     = state;
        stall_o = False;
        wd_o    = wd_i;
        wreg_o  = wreg_i;
        wdata_o = wdata_i;
        case (state)
            IDLE: if (is_mem(mem_op_i)) begin
                nxt     = XFER;
                stall_o = True;
                wreg_o  = False;
            end
            XFER: begin
                stall_o = True;
                wreg_o  = False;
                if (mem_ready_i && cnt == last_byte(f3_q)) nxt = DONE;
            end
            DONE: begin
                nxt     = IDLE;
                wdata_o = store_q ? wdata_i : XLEN'(ext_data);
            end
            default: nxt = IDLE;
        endcase
        if (rst == RstEnable) begin
            wd_o    = '0;
            wreg_o  = False;
            wdata_o = '0;
            stall_o = False;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: table-driven check of the MEM stage against a byte memory
// model, plus hand-written ready-toggle, reset and back-to-back sequences.
module tb_mem_access_stage;

    logic        clk = 0;
    logic        rst = 0;
    logic [4:0]  wd_i = 0;
    logic        wreg_i = 0;
    logic [31:0] wdata_i = 0;
    logic [31:0] memaddr_i = 0;
    logic [4:0]  mem_op_i = 0;
    logic [31:0] store_data_i = 0;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic [7:0]  mem_rdata_i;
    logic        mem_ready_i = 1;

    int passed = 0;
    int total  = 0;

    logic [7:0]  mem   [256];
    int          xfers = 0;
    logic [31:0] xaddr [64];
    logic [7:0]  xdata [64];
    logic        xwe   [64];

    mem_access_stage dut (
        .clk          (clk),
        .rst          (rst),
        .wd_i         (wd_i),
        .wreg_i       (wreg_i),
        .wdata_i      (wdata_i),
        .memaddr_i    (memaddr_i),
        .mem_op_i     (mem_op_i),
        .store_data_i (store_data_i),
        .wd_o         (wd_o),
        .wreg_o       (wreg_o),
        .wdata_o      (wdata_o),
        .stall_o      (stall_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ready_i  (mem_ready_i)
    );

    always #5 clk = ~clk;

    assign mem_rdata_i = mem[mem_addr_o[7:0]];

    // Record every completed byte transfer.
    always @(posedge clk) begin
        if (mem_req_o && mem_ready_i) begin
            xaddr[xfers % 64] <= mem_addr_o;
            xdata[xfers % 64] <= mem_wdata_o;
            xwe[xfers % 64]   <= mem_we_o;
            xfers             <= xfers + 1;
        end
    end

    typedef struct {
        logic [4:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] wdata;
        logic [31:0] bytes;
        logic [31:0] exp;
        int          stalls;
    } vec_t;

    vec_t v [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run(input vec_t t, input string nm);
        int n, st, x0;
        logic [31:0] a;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            a = t.addr + k;
            mem[a[7:0]] = t.bytes[8*k +: 8];
        end
        wd_i         = t.wdata[4:0];
        wreg_i       = 1'b1;
        wdata_i      = t.wdata;
        memaddr_i    = t.addr;
        mem_op_i     = t.op;
        store_data_i = t.sdata;
        n  = t.stalls == 0 ? 0 : t.stalls - 1;
        x0 = xfers;
        st = 0;
        @(negedge clk);
        chk({nm, ".req_at_issue"}, 32'(mem_req_o), 0);
        for (int c = 0; c < 40 && stall_o; c++) begin
            st++;
            @(negedge clk);
        end
        chk({nm, ".stall_cycles"}, st, t.stalls);
        chk({nm, ".wdata"}, wdata_o, t.exp);
        chk({nm, ".wd"}, 32'(wd_o), 32'(t.wdata[4:0]));
        chk({nm, ".wreg"}, 32'(wreg_o), 1);
        chk({nm, ".xfer_count"}, xfers - x0, n);
        for (int k = 0; k < n; k++) begin
            chk({nm, ".addr"}, xaddr[(x0 + k) % 64], t.addr + k);
            chk({nm, ".we"}, 32'(xwe[(x0 + k) % 64]), 32'(t.op[3]));
            if (t.op[3]) chk({nm, ".wbyte"}, 32'(xdata[(x0 + k) % 64]), 32'(t.sdata[8*k +: 8]));
        end
    endtask

    initial begin
        int x0;
        v[0]  = '{5'h00, 32'h0000_0000, 32'h0,          32'h0000_1234, 32'h0,          32'h0000_1234, 0};
        v[1]  = '{5'h12, 32'h0000_0100, 32'h0,          32'h0000_0001, 32'h1234_5678, 32'h1234_5678, 5};
        v[2]  = '{5'h10, 32'h0000_0210, 32'h0,          32'h0000_0002, 32'h0000_0080, 32'hFFFF_FF80, 2};
        v[3]  = '{5'h14, 32'h0000_0210, 32'h0,          32'h0000_0003, 32'h0000_0080, 32'h0000_0080, 2};
        v[4]  = '{5'h11, 32'h0000_0220, 32'h0,          32'h0000_0004, 32'h0000_8001, 32'hFFFF_8001, 3};
        v[5]  = '{5'h15, 32'h0000_0220, 32'h0,          32'h0000_0005, 32'h0000_8001, 32'h0000_8001, 3};
        v[6]  = '{5'h1A, 32'h0000_0130, 32'h1122_3344, 32'h0000_CAFE, 32'h0,          32'h0000_CAFE, 5};
        v[7]  = '{5'h18, 32'h0000_0140, 32'h0000_0099, 32'h0000_0077, 32'h0,          32'h0000_0077, 2};
        v[8]  = '{5'h13, 32'h0000_0150, 32'h0,          32'h0000_BEEF, 32'h0,          32'h0000_BEEF, 0};
        v[9]  = '{5'h12, 32'h0000_01FE, 32'h0,          32'h0000_0009, 32'hA1B2_C3D4, 32'hA1B2_C3D4, 5};
        v[10] = '{5'h10, 32'h0000_0230, 32'h0,          32'h0000_000A, 32'h0000_007F, 32'h0000_007F, 2};
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset gating with non-zero pass-through inputs applied.
        wd_i = 5'd7; wreg_i = 1; wdata_i = 32'hFF; mem_op_i = 5'h00;
        #3;
        chk("rst.wd", 32'(wd_o), 0);
        chk("rst.wreg", 32'(wreg_o), 0);
        chk("rst.wdata", wdata_o, 0);
        chk("rst.stall", 32'(stall_o), 0);
        chk("rst.req", 32'(mem_req_o), 0);
        chk("rst.addr", mem_addr_o, 0);
        @(negedge clk);
        rst = 1;

        for (int i = 0; i < 11; i++) run(v[i], $sformatf("vec%0d", i));

        // SH across the address wrap with ready toggling 0,1,0,1.
        @(posedge clk); #1;
        mem_op_i = 5'h19; memaddr_i = 32'hFFFF_FFFF; store_data_i = 32'hAABB_CCDD;
        wdata_i = 32'h55; wd_i = 5'd3; mem_ready_i = 0; x0 = xfers;
        @(negedge clk);
        chk("sh.issue_stall", 32'(stall_o), 1);
        @(posedge clk); #1 mem_ready_i = 0;
        @(negedge clk);
        chk("sh.req", 32'(mem_req_o), 1);
        chk("sh.we", 32'(mem_we_o), 1);
        chk("sh.addr0", mem_addr_o, 32'hFFFF_FFFF);
        chk("sh.data0", 32'(mem_wdata_o), 32'hDD);
        @(posedge clk); #1 mem_ready_i = 1;
        @(negedge clk);
        chk("sh.addr0_held", mem_addr_o, 32'hFFFF_FFFF);
        chk("sh.data0_held", 32'(mem_wdata_o), 32'hDD);
        @(posedge clk); #1 mem_ready_i = 0;
        @(negedge clk);
        chk("sh.addr1", mem_addr_o, 32'h0);
        chk("sh.data1", 32'(mem_wdata_o), 32'hCC);
        chk("sh.stall_wait", 32'(stall_o), 1);
        @(posedge clk); #1 mem_ready_i = 1;
        @(negedge clk);
        chk("sh.addr1_held", mem_addr_o, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("sh.done_stall", 32'(stall_o), 0);
        chk("sh.done_wdata", wdata_o, 32'h55);
        chk("sh.done_req", 32'(mem_req_o), 0);
        chk("sh.xfers", xfers - x0, 2);

        // Reset during an LW after two bytes, then a fresh LB.
        @(posedge clk); #1;
        mem_op_i = 5'h12; memaddr_i = 32'h100; mem_ready_i = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        #1;
        chk("rstmid.req", 32'(mem_req_o), 0);
        chk("rstmid.stall", 32'(stall_o), 0);
        chk("rstmid.wdata", wdata_o, 0);
        mem_op_i = 5'h00;
        @(negedge clk);
        rst = 1;
        run(v[2], "after_rst_lb");

        // Back-to-back LW then SB.
        run(v[1], "b2b_lw");
        run(v[7], "b2b_sb");

        @(posedge clk); #1 mem_op_i = 5'h00;
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
